// File: rtl/rx_frame_filter.sv
// RX frame filter: drains the RX byte FIFO, checks destination MAC and CRC-32 FCS, strips the FCS.
// Define RXF_MULTICAST_EN to also accept group (multicast) destination addresses.

module my_bin2gray #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

module rx_frame_filter #(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter int unsigned MIN_LEN  = 64
) (
  input  logic        REF_CLK,
  input  logic        arst_n,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_EOD_out,
  output logic        fifo_rden,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        m_err,
  output logic [15:0] good_count_gray,
  output logic [15:0] err_count_gray,
  output logic [15:0] drop_count_gray
);

  localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
  localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

  typedef enum logic [2:0] {StIdle, StHdr, StBody, StFlush, StDrop} state_e;

  state_e          state_q, state_d;
  logic [5:0][7:0] line_q, line_d;
  logic [31:0]     crc_q, crc_d, crc_nx;
  logic [15:0]     cnt_q, cnt_d, cnt_inc;
  logic            bad_q, bad_d;
  logic [1:0]      flush_q, flush_d;
  logic            rd_q, run_q;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d, last_q, last_d, err_q, err_d;
  logic [15:0]     good_q, good_d, errc_q, errc_d, drop_q, drop_d;
  logic [47:0]     da;
  logic            da_ok, out_free, xfer;
  logic [5:0][7:0] line_shift;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  assign crc_nx     = crc_byte(crc_q, fifo_dout);
  assign cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign line_shift = {fifo_dout, line_q[5:1]};
  assign out_free   = !valid_q || m_ready;
  assign xfer       = valid_q && m_ready;

  // DA is b0..b4 already in the line plus b5 arriving now.
  assign da = {line_q[1], line_q[2], line_q[3], line_q[4], line_q[5], fifo_dout};
`ifdef RXF_MULTICAST_EN
  assign da_ok = (da == MAC_ADDR) || (&da) || da[40];
`else
  assign da_ok = (da == MAC_ADDR) || (&da);
`endif

  always_comb begin
    fifo_rden = 1'b0;
    if (run_q && !fifo_empty && !rd_q) begin
      unique case (state_q)
        StIdle, StHdr, StDrop: fifo_rden = 1'b1;
        StBody:                fifo_rden = out_free;
        default:               fifo_rden = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    flush_d = flush_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = err_q;
    good_d  = good_q;
    errc_d  = errc_q;
    drop_d  = drop_q;
    if (xfer) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      err_d   = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (rd_q) begin
          line_d = line_shift;
          crc_d  = crc_nx;
          cnt_d  = cnt_inc;
          if (fifo_EOD_out) drop_d = drop_q + 16'd1;
          else              state_d = StHdr;
        end
      end
      StHdr: begin
        if (rd_q) begin
          line_d = line_shift;
          crc_d  = crc_nx;
          cnt_d  = cnt_inc;
          if (fifo_EOD_out) begin
            drop_d  = drop_q + 16'd1;
            state_d = StIdle;
          end else if (cnt_q == 16'd5) begin
            state_d = da_ok ? StBody : StDrop;
          end
        end
      end
      StBody: begin
        if (rd_q) begin
          data_d  = line_q[0];
          valid_d = 1'b1;
          last_d  = 1'b0;
          err_d   = 1'b0;
          line_d  = line_shift;
          crc_d   = crc_nx;
          cnt_d   = cnt_inc;
          if (fifo_EOD_out) begin
            bad_d   = (crc_nx != CrcResidue) || ({16'h0, cnt_inc} < MIN_LEN);
            flush_d = 2'd0;
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        // Line now holds b(N-6)..b(N-1); only the first two are payload.
        if (flush_q == 2'd0 && out_free) begin
          data_d  = line_q[0];
          valid_d = 1'b1;
          last_d  = 1'b0;
          err_d   = 1'b0;
          flush_d = 2'd1;
        end else if (flush_q == 2'd1 && out_free) begin
          data_d  = line_q[1];
          valid_d = 1'b1;
          last_d  = 1'b1;
          err_d   = bad_q;
          flush_d = 2'd2;
        end else if (flush_q == 2'd2 && xfer) begin
          if (err_q) errc_d = errc_q + 16'd1;
          else       good_d = good_q + 16'd1;
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (rd_q && fifo_EOD_out) begin
          drop_d  = drop_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StIdle) begin
      line_d = '0;
      crc_d  = '1;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StIdle;
      line_q  <= '0;
      crc_q   <= '1;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      flush_q <= 2'd0;
      rd_q    <= 1'b0;
      run_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      good_q  <= '0;
      errc_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      flush_q <= flush_d;
      rd_q    <= fifo_rden;
      run_q   <= 1'b1;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      good_q  <= good_d;
      errc_q  <= errc_d;
      drop_q  <= drop_d;
    end
  end

  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign m_last  = last_q;
  assign m_err   = err_q;

  my_bin2gray #(.WIDTH(16)) u_good_gray (.bin(good_q), .gray(good_count_gray));
  my_bin2gray #(.WIDTH(16)) u_err_gray  (.bin(errc_q), .gray(err_count_gray));
  my_bin2gray #(.WIDTH(16)) u_drop_gray (.bin(drop_q), .gray(drop_count_gray));

endmodule

// File: tb/tb_rx_frame_filter.sv
// Bench for rx_frame_filter: FIFO model feeds frames, a frame-level model predicts the stream.

module tb_rx_frame_filter;

  localparam logic [47:0] Mac    = 48'h02_00_00_00_00_01;
  localparam int          MinLen = 64;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_eod = 1'b0;
  logic        fifo_rden;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic        m_err;
  logic [15:0] good_gray, err_gray, drop_gray;

  always #5 clk = ~clk;

  rx_frame_filter #(.MAC_ADDR(Mac), .MIN_LEN(MinLen)) dut (
    .REF_CLK(clk), .arst_n(arst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_EOD_out(fifo_eod), .fifo_rden(fifo_rden), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .m_err(m_err), .good_count_gray(good_gray),
    .err_count_gray(err_gray), .drop_count_gray(drop_gray)
  );

  int vectors = 0;
  int miscompares = 0;
  int mg = 0, me = 0, md = 0;  // model good / err / drop counts
  int ready_mode = 0;          // 0: ready high, 1: random, 2: ready low
  int underflow = 0;

  // FIFO model: data appears the cycle after fifo_rden; reset flushes unread bytes.
  logic [7:0] fmem [16384];
  logic       feod [16384];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rden) begin
      if (rd_ptr == wr_ptr) underflow <= underflow + 1;
      fifo_dout <= fmem[rd_ptr[13:0]];
      fifo_eod  <= feod[rd_ptr[13:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      m_ready = 1'b1;
    else if (ready_mode == 1) m_ready = ($urandom_range(0, 3) != 0);
    else                      m_ready = 1'b0;
  end

  logic [9:0] cap_q [$];
  logic [9:0] exp_q [$];
  always @(negedge clk) begin
    if (arst_n && m_valid && m_ready) cap_q.push_back({m_err, m_last, m_data});
  end

  function automatic logic [31:0] crc32(input logic [7:0] f[$], input int len);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ f[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] gray16(input int v);
    logic [15:0] b;
    b = v[15:0];
    return b ^ (b >> 1);
  endfunction

  task automatic build_frame(input logic [47:0] da, input int n, output logic [7:0] f[$]);
    logic [31:0] c;
    f.delete();
    for (int i = 0; i < n - 4; i++) f.push_back(i < 6 ? da[47-8*i -: 8] : 8'($urandom));
    c = ~crc32(f, n - 4);
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
  endtask

  // Frame-level expectation: appends the payload stream to exp_q and bumps model counters.
  task automatic model_frame(input logic [7:0] f[$]);
    int n;
    logic [47:0] da;
    logic [31:0] fcs;
    bit acc, bad;
    n = f.size();
    if (n <= 6) begin
      md++;
      return;
    end
    da = {f[0], f[1], f[2], f[3], f[4], f[5]};
    acc = (da == Mac) || (da == 48'hFFFF_FFFF_FFFF);
`ifdef RXF_MULTICAST_EN
    acc = acc || f[0][0];
`endif
    if (!acc) begin
      md++;
      return;
    end
    fcs = {f[n-1], f[n-2], f[n-3], f[n-4]};
    bad = (fcs != ~crc32(f, n - 4)) || (n < MinLen);
    for (int i = 0; i < n - 4; i++) exp_q.push_back({bad && (i == n - 5), i == n - 5, f[i]});
    if (bad) me++;
    else     mg++;
  endtask

  task automatic push_frame(input logic [7:0] f[$], input int max_gap);
    @(negedge clk);
    for (int i = 0; i < f.size(); i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      fmem[wr_ptr[13:0]] = f[i];
      feod[wr_ptr[13:0]] = (i == f.size() - 1);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic wait_idle(input int base, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20000 && !ok; c++) begin
      @(negedge clk);
      ok = (rd_ptr == wr_ptr) && (cap_q.size() - base >= exp_q.size());
    end
    repeat (8) @(negedge clk);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d bytes, want %0d", name, cap_q.size() - base, exp_q.size());
    end
  endtask

  function automatic int stream_diff(input int base);
    if (cap_q.size() - base != exp_q.size()) return -2;
    for (int i = 0; i < exp_q.size(); i++) if (cap_q[base+i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors += 4;
    if (fifo_rden !== 1'b0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: rden=%b valid=%b, want 0 0", fifo_rden, m_valid);
    end
    if ({m_data, m_last, m_err} !== 10'h0) begin
      miscompares++;
      $display("FAIL reset_data: data=%h last=%b err=%b, want 0", m_data, m_last, m_err);
    end
    if (good_gray !== 16'h0 || err_gray !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_cnt: good=%h err=%h, want 0 0", good_gray, err_gray);
    end
    if (drop_gray !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_drop: drop=%h, want 0", drop_gray);
    end
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame;
    logic [7:0] f[$];
    int base, d;
    exp_q.delete();
    base = cap_q.size();
    build_frame(Mac, 64, f);
    model_frame(f);
    push_frame(f, 0);
    wait_idle(base, "good");
    d = stream_diff(base);
    vectors += 2;
    if (d != -1) begin
      miscompares++;
      $display("FAIL good_stream: diff %0d, got %0d bytes, want %0d", d, cap_q.size() - base,
               exp_q.size());
    end
    if (good_gray !== gray16(mg) || err_gray !== gray16(me)) begin
      miscompares++;
      $display("FAIL good_count: good=%h err=%h, want %h %h", good_gray, err_gray, gray16(mg),
               gray16(me));
    end
  endtask

  task automatic test_crc_error;
    logic [7:0] f[$];
    int base, d;
    exp_q.delete();
    base = cap_q.size();
    build_frame(Mac, 64, f);
    f[20] = f[20] ^ 8'h10;
    model_frame(f);
    push_frame(f, 0);
    wait_idle(base, "crc");
    d = stream_diff(base);
    vectors += 2;
    if (d != -1) begin
      miscompares++;
      $display("FAIL crc_stream: diff %0d, got %0d bytes, want %0d", d, cap_q.size() - base,
               exp_q.size());
    end
    if (err_gray !== gray16(me) || good_gray !== gray16(mg)) begin
      miscompares++;
      $display("FAIL crc_count: err=%h good=%h, want %h %h", err_gray, good_gray, gray16(me),
               gray16(mg));
    end
  endtask

  task automatic test_drop;
    logic [7:0] f[$];
    int base;
    exp_q.delete();
    base = cap_q.size();
    build_frame(48'h02_00_00_00_00_02, 64, f);
    model_frame(f);
    push_frame(f, 0);
    wait_idle(base, "drop");
    vectors += 2;
    if (cap_q.size() - base != 0 || rd_ptr != wr_ptr) begin
      miscompares++;
      $display("FAIL drop_stream: out=%0d unread=%0d, want 0 0", cap_q.size() - base,
               wr_ptr - rd_ptr);
    end
    if (drop_gray !== gray16(md)) begin
      miscompares++;
      $display("FAIL drop_count: drop=%h, want %h", drop_gray, gray16(md));
    end
    f.delete();
    for (int i = 0; i < 5; i++) f.push_back(Mac[47-8*i -: 8]);
    model_frame(f);
    push_frame(f, 0);
    wait_idle(base, "short");
    vectors += 2;
    if (cap_q.size() - base != 0) begin
      miscompares++;
      $display("FAIL short_stream: out=%0d, want 0", cap_q.size() - base);
    end
    if (drop_gray !== gray16(md)) begin
      miscompares++;
      $display("FAIL short_count: drop=%h, want %h", drop_gray, gray16(md));
    end
  endtask

  task automatic test_group_addr;
    logic [7:0] f[$];
    int base, d;
    exp_q.delete();
    base = cap_q.size();
    build_frame(48'hFF_FF_FF_FF_FF_FF, 64, f);
    model_frame(f);
    push_frame(f, 0);
    build_frame(48'h01_00_5E_00_00_01, 64, f);
    model_frame(f);
    push_frame(f, 0);
    wait_idle(base, "group");
    d = stream_diff(base);
    vectors += 2;
    if (d != -1) begin
      miscompares++;
      $display("FAIL group_stream: diff %0d, got %0d bytes, want %0d", d, cap_q.size() - base,
               exp_q.size());
    end
    if (good_gray !== gray16(mg) || drop_gray !== gray16(md)) begin
      miscompares++;
      $display("FAIL group_count: good=%h drop=%h, want %h %h", good_gray, drop_gray,
               gray16(mg), gray16(md));
    end
  endtask

  task automatic test_stall;
    logic [7:0] f[$];
    int base, d, rs, held;
    bit ok;
    exp_q.delete();
    base = cap_q.size();
    build_frame(Mac, 64, f);
    model_frame(f);
    push_frame(f, 0);
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      ok = (cap_q.size() - base >= 20);
    end
    ready_mode = 2;
    repeat (4) @(negedge clk);
    rs = rd_ptr;
    held = cap_q.size() - base;
    repeat (96) @(negedge clk);
    vectors += 3;
    if (!ok || rd_ptr != rs) begin
      miscompares++;
      $display("FAIL stall_rden: reached=%b reads=%0d, want 1 0", ok, rd_ptr - rs);
    end
    if (m_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_valid: valid=%b, want 1", m_valid);
    end
    if (held >= exp_q.size() || m_data !== exp_q[held][7:0]) begin
      miscompares++;
      $display("FAIL stall_hold: data=%h at byte %0d, want %h", m_data, held,
               exp_q[held % exp_q.size()][7:0]);
    end
    ready_mode = 0;
    wait_idle(base, "stall");
    d = stream_diff(base);
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("FAIL stall_stream: diff %0d, got %0d bytes, want %0d", d, cap_q.size() - base,
               exp_q.size());
    end
  endtask

  task automatic test_runt;
    logic [7:0] f[$];
    int base, d;
    exp_q.delete();
    base = cap_q.size();
    build_frame(Mac, 40, f);
    model_frame(f);
    push_frame(f, 0);
    wait_idle(base, "runt");
    d = stream_diff(base);
    vectors += 2;
    if (d != -1) begin
      miscompares++;
      $display("FAIL runt_stream: diff %0d, got %0d bytes, want %0d", d, cap_q.size() - base,
               exp_q.size());
    end
    if (err_gray !== gray16(me)) begin
      miscompares++;
      $display("FAIL runt_count: err=%h, want %h", err_gray, gray16(me));
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] f[$];
    logic [47:0] da;
    int base, d, kind, n;
    exp_q.delete();
    base = cap_q.size();
    ready_mode = 1;
    for (int k = 0; k < 10; k++) begin
      kind = $urandom_range(0, 5);
      n = $urandom_range(7, 90);
      unique case (kind)
        0, 4:    da = Mac;
        1:       da = 48'hFF_FF_FF_FF_FF_FF;
        2:       da = 48'h02_00_00_00_00_55;
        default: da = 48'h01_00_5E_00_00_07;
      endcase
      build_frame(da, n, f);
      if (kind == 4) begin
        d = $urandom_range(6, n - 1);
        f[d] = f[d] ^ 8'h01;
      end
      if (kind == 5) begin
        f.delete();
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) f.push_back(Mac[47-8*i -: 8]);
      end
      model_frame(f);
      push_frame(f, 3);
    end
    wait_idle(base, "b2b");
    ready_mode = 0;
    d = stream_diff(base);
    vectors += 3;
    if (d != -1) begin
      miscompares++;
      $display("FAIL b2b_stream: diff %0d, got %0d bytes, want %0d", d, cap_q.size() - base,
               exp_q.size());
    end
    if ({good_gray, err_gray, drop_gray} !== {gray16(mg), gray16(me), gray16(md)}) begin
      miscompares++;
      $display("FAIL b2b_count: %h %h %h, want %h %h %h", good_gray, err_gray, drop_gray,
               gray16(mg), gray16(me), gray16(md));
    end
    if (underflow != 0) begin
      miscompares++;
      $display("FAIL b2b_underflow: reads of empty fifo=%0d, want 0", underflow);
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] f[$];
    int base, d;
    exp_q.delete();
    build_frame(Mac, 64, f);
    push_frame(f, 0);
    base = cap_q.size();
    for (int c = 0; c < 2000 && cap_q.size() - base < 10; c++) @(negedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    mg = 0;
    me = 0;
    md = 0;
    vectors += 2;
    if ({m_valid, m_data, m_last, m_err, fifo_rden} !== 12'h0) begin
      miscompares++;
      $display("FAIL arst_out: valid=%b data=%h last=%b err=%b rden=%b, want 0", m_valid,
               m_data, m_last, m_err, fifo_rden);
    end
    if ({good_gray, err_gray, drop_gray} !== 48'h0) begin
      miscompares++;
      $display("FAIL arst_cnt: %h %h %h, want 0 0 0", good_gray, err_gray, drop_gray);
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    base = cap_q.size();
    build_frame(Mac, 70, f);
    model_frame(f);
    push_frame(f, 0);
    wait_idle(base, "arst");
    d = stream_diff(base);
    vectors += 2;
    if (d != -1) begin
      miscompares++;
      $display("FAIL arst_stream: diff %0d, got %0d bytes, want %0d", d, cap_q.size() - base,
               exp_q.size());
    end
    if ({good_gray, err_gray, drop_gray} !== {gray16(mg), gray16(me), gray16(md)}) begin
      miscompares++;
      $display("FAIL arst_after: %h %h %h, want %h %h %h", good_gray, err_gray, drop_gray,
               gray16(mg), gray16(me), gray16(md));
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_drop();
    test_group_addr();
    test_stall();
    test_runt();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
